// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcode and FSM state
// enums plus small opcode decode helpers.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Operands are reduced to magnitudes at start; sign is restored in the FIX cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  state_e             state;
  state_e             next_state;
  logic [CNT_W-1:0]   counter;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_r;
  logic               zero_div_q;
  logic [WIDTH-1:0]   operand_b;
  logic [2*WIDTH-1:0] work;

  op_e              op_sel;
  logic             signed_op;
  logic             div_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_sel    = op_e'(op);
  assign signed_op = op_is_signed(op_sel);
  assign div_op    = op_is_div(op_sel);
  assign a_mag     = signed_op ? abs_val(a) : a;
  assign b_mag     = signed_op ? abs_val(b) : b;

  // For multiply, work = {partial product high, remaining multiplier bits};
  // for divide, work = {partial remainder, dividend bits becoming quotient}.
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] work_next;

  always_comb begin
    mult_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? operand_b : {WIDTH{1'b0}})};
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand_b};
    div_ok    = ~div_diff[WIDTH];
    if (is_div_q)
      work_next = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), work[WIDTH-2:0], div_ok};
    else
      work_next = {mult_sum, work[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] mult_result;
  logic [WIDTH-1:0]   quot_result;
  logic [WIDTH-1:0]   rem_result;

  always_comb begin
    mult_result = neg_q ? -work : work;
    quot_result = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_result  = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Division by zero skips the iteration phase entirely.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start)
          next_state = (div_op && (b == '0)) ? S_FIX : S_RUN;
      end
      S_RUN: begin
        if (counter == LAST_ITER)
          next_state = S_FIX;
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      zero_div_q <= 1'b0;
      operand_b  <= '0;
      work       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            counter    <= '0;
            is_div_q   <= div_op;
            neg_q      <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r      <= signed_op & a[WIDTH-1];
            zero_div_q <= div_op && (b == '0);
            if (div_op) begin
              operand_b <= b_mag;
              work      <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              operand_b <= a_mag;
              work      <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        S_RUN: begin
          work    <= work_next;
          counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Architectural writes from MTHI/MTLO only land while idle; FIX owns them otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= (state == S_FIX);
      div_zero <= (state == S_FIX) && zero_div_q;
      if (state == S_IDLE) begin
        if (hi_we)
          hi <= a;
        if (lo_we)
          lo <= a;
      end else if ((state == S_FIX) && !zero_div_q) begin
        if (is_div_q) begin
          lo <= quot_result;
          hi <= rem_result;
        end else begin
          {hi, lo} <= mult_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand-written sequences
// for preemption, mid-operation reset and back-to-back issue.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done)
      done_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeHiLo(input logic [W-1:0] hv, input logic [W-1:0] lv);
    hi_we = 1'b1; a = hv;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b1; a = lv;
    @(negedge clock);
    lo_we = 1'b0;
  endtask

  task automatic startOp(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clock);
    start = 1'b0; op = 2'b00; a = '0; b = '0;
  endtask

  task automatic waitDone(input string name, input int exp_cycles);
    int cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput({name, " latency"}, 64'(cycles), 64'(exp_cycles));
  endtask

  task automatic applyStimulus(input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    writeHiLo(32'h0000_1234, 32'h0000_5678);
    startOp(vecs[idx].op, vecs[idx].a, vecs[idx].b);
    checkOutput({nm, " busy"}, 64'(busy), 64'd1);
    waitDone(nm, vecs[idx].exp_dz ? 1 : W + 1);
    checkOutput({nm, " hi"}, 64'(hi), 64'(vecs[idx].exp_hi));
    checkOutput({nm, " lo"}, 64'(lo), 64'(vecs[idx].exp_lo));
    checkOutput({nm, " div_zero"}, 64'(div_zero), 64'(vecs[idx].exp_dz));
    checkOutput({nm, " idle at done"}, 64'(busy), 64'd0);
    @(negedge clock);
    checkOutput({nm, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int base;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'd100,       32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 1'b1};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[7]  = '{2'b00, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'b10, 32'h8000_0000, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 1'b1};
    vecs[11] = '{2'b00, 32'd12345,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7, 1'b0};
    vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset div_zero", 64'(div_zero), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < 13; i++)
      applyStimulus(i);

    // Second start while RUN must neither restart nor queue another op.
    base = done_count;
    startOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    checkOutput("preempt busy", 64'(busy), 64'd1);
    waitDone("preempt", W + 1 - 6);
    checkOutput("preempt hi", 64'(hi), 64'h0);
    checkOutput("preempt lo", 64'(lo), 64'h8000_0000);
    repeat (40) @(negedge clock);
    #1;
    checkOutput("preempt done count", 64'(done_count - base), 64'd1);

    // Reset during RUN aborts without a result.
    writeHiLo(32'h1111, 32'h2222);
    base = done_count;
    startOp(2'b01, 32'd5, 32'd5);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'd0);
    checkOutput("abort lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clock);
    #1;
    checkOutput("abort no done", 64'(done_count - base), 64'd0);
    startOp(2'b00, 32'hFFFF_FFF9, 32'd3);
    waitDone("post-abort", W + 1);
    checkOutput("post-abort result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Back-to-back issue in the done cycle; MTLO while busy is dropped.
    startOp(2'b01, 32'd2, 32'd3);
    lo_we = 1'b1; a = 32'h0000_ABCD;
    @(negedge clock);
    lo_we = 1'b0; a = '0;
    waitDone("b2b first", W);
    checkOutput("b2b first lo", 64'(lo), 64'd6);
    startOp(2'b01, 32'd4, 32'd5);
    checkOutput("b2b accepted", 64'(busy), 64'd1);
    waitDone("b2b second", W + 1);
    checkOutput("b2b second lo", 64'(lo), 64'd20);
    lo_we = 1'b1; a = 32'h0000_ABCD;
    @(negedge clock);
    lo_we = 1'b0;
    checkOutput("mtlo idle lo", 64'(lo), 64'h0000_ABCD);
    checkOutput("mtlo idle hi", 64'(hi), 64'd0);

    // Both MT writes alongside a divide-by-zero start: writes land and survive.
    hi_we = 1'b1; lo_we = 1'b1;
    startOp(2'b11, 32'h0000_0077, 32'h0);
    hi_we = 1'b0; lo_we = 1'b0;
    checkOutput("mt+start hi", 64'(hi), 64'h77);
    checkOutput("mt+start lo", 64'(lo), 64'h77);
    waitDone("mt+start", 1);
    checkOutput("mt+start div_zero", 64'(div_zero), 64'd1);
    checkOutput("mt+start hi kept", 64'(hi), 64'h77);
    checkOutput("mt+start lo kept", 64'(lo), 64'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
